// File: rtl/stepper_pkg.sv
// Shared types and default constants for the stepper step-timing and phase stages.
package stepper_pkg;

    localparam int unsigned CNT_W_DEF = 24;
    localparam int unsigned DIV_W_DEF = 16;

    localparam logic [15:0] START_PERIOD_DEF = 16'd2000;
    localparam logic [15:0] RAMP_DEC_DEF     = 16'd4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEL  = 2'd1,
        CRUISE = 2'd2,
        DECEL  = 2'd3
    } step_state_t;

    // Phase-state encoding used by the downstream phase next-state stage.
    typedef enum logic [1:0] {
        PH_A = 2'd0,
        PH_B = 2'd1,
        PH_C = 2'd2,
        PH_D = 2'd3
    } phase_t;

endpackage

// File: rtl/stepper_period_timer.sv
// Step-interval down-counter: expire_c is high in the cycle a step must be scheduled,
// load_val cycles after the load (including the load cycle itself for load_val == 1).
module stepper_period_timer #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    output logic             expire_c
);

    logic [DIV_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val - DIV_W'(1);
        end else if (cnt != '0) begin
            cnt <= cnt - DIV_W'(1);
        end
    end

    assign expire_c = load ? (load_val == DIV_W'(1)) : (cnt == DIV_W'(1));

endmodule

// File: rtl/stepper_step_gen.sv
// Move-command step generator: trapezoidal/triangular period ramp driving one-cycle
// step_en pulses with a latched direction.
module stepper_step_gen
    import stepper_pkg::*;
#(
    parameter int unsigned      CNT_W        = CNT_W_DEF,
    parameter int unsigned      DIV_W        = DIV_W_DEF,
    parameter logic [DIV_W-1:0] START_PERIOD = DIV_W'(START_PERIOD_DEF),
    parameter logic [DIV_W-1:0] RAMP_DEC     = DIV_W'(RAMP_DEC_DEF)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic             cmd_dir,
    input  logic [DIV_W-1:0] cmd_period,
    input  logic             abort,
    output logic             step_en,
    output logic             step_dir,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] steps_left
);

    step_state_t      state_q, state_d;
    logic [DIV_W-1:0] cur_q, cur_d, tgt_q, tgt_d;
    logic [DIV_W-1:0] cur_up, cur_dn, period_clamped, load_val;
    logic [CNT_W-1:0] ramp_q, ramp_d, steps_d, r_dec;
    logic             dir_d, done_d, aborted_d, load;
    logic             accept, fire, expire_c, plain_cruise;

    assign cmd_ready      = (state_q == IDLE) && !rst;
    assign accept         = cmd_valid && cmd_ready;
    assign period_clamped = (cmd_period == '0) ? DIV_W'(1) : cmd_period;
    assign r_dec          = steps_left - CNT_W'(1);
    // A cruise entered directly (target not faster than standstill) never ramps.
    assign plain_cruise   = (state_q == CRUISE) && (ramp_q == '0);

    assign cur_dn = ((cur_q > tgt_q) && ((cur_q - tgt_q) > RAMP_DEC)) ?
                    (cur_q - RAMP_DEC) : tgt_q;
    assign cur_up = ((cur_q < START_PERIOD) && ((START_PERIOD - cur_q) > RAMP_DEC)) ?
                    (cur_q + RAMP_DEC) : START_PERIOD;

    // Abort while moving drops the pulse the timer would schedule this cycle.
    assign fire = expire_c && ((state_q == IDLE) ? load : !abort);

    stepper_period_timer #(
        .DIV_W (DIV_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .expire_c (expire_c)
    );

    // Next-state, ramp arithmetic and timer reload.
    always_comb begin
        state_d   = state_q;
        steps_d   = steps_left;
        cur_d     = cur_q;
        ramp_d    = ramp_q;
        tgt_d     = tgt_q;
        dir_d     = step_dir;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        load      = 1'b0;
        load_val  = cur_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    steps_d = cmd_steps;
                    dir_d   = cmd_dir;
                    tgt_d   = period_clamped;
                    cur_d   = START_PERIOD;
                    ramp_d  = '0;
                    if (cmd_steps == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d  = (period_clamped < START_PERIOD) ? ACCEL : CRUISE;
                        load     = 1'b1;
                        load_val = START_PERIOD;
                    end
                end
            end
            default: begin
                if (abort) begin
                    state_d   = IDLE;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                    if (step_en) begin
                        steps_d = r_dec;
                    end
                end else if (step_en) begin
                    steps_d = r_dec;
                    if (r_dec == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        if (!plain_cruise && (r_dec <= ramp_q)) begin
                            state_d = DECEL;
                            cur_d   = cur_up;
                            ramp_d  = (ramp_q == '0) ? '0 : (ramp_q - CNT_W'(1));
                        end else if (state_q == ACCEL) begin
                            cur_d  = cur_dn;
                            ramp_d = ramp_q + CNT_W'(1);
                            if (cur_dn == tgt_q) begin
                                state_d = CRUISE;
                            end
                        end
                        load     = 1'b1;
                        load_val = cur_d;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cur_q      <= START_PERIOD;
            tgt_q      <= DIV_W'(1);
            ramp_q     <= '0;
            step_en    <= 1'b0;
            step_dir   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            steps_left <= '0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            tgt_q      <= tgt_d;
            ramp_q     <= ramp_d;
            step_en    <= fire;
            step_dir   <= dir_d;
            busy       <= (state_d != IDLE);
            done       <= done_d;
            aborted    <= aborted_d;
            steps_left <= steps_d;
        end
    end

endmodule

// File: tb/tb_stepper_step_gen.sv
// Bench for stepper_step_gen: per-cycle expected outputs built from the move rules,
// plus hand-computed pulse timings for the directed moves.
module tb_stepper_step_gen;

    localparam int MAXC  = 1024;
    localparam int START = 8;
    localparam int DEC   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [23:0] cmd_steps = '0;
    logic        cmd_dir = 1'b0;
    logic [15:0] cmd_period = '0;
    logic        abort = 1'b0;
    logic        step_en, step_dir, busy, done, aborted;
    logic [23:0] steps_left;

    logic        c1_valid = 1'b0;
    logic        c1_ready;
    logic [23:0] c1_steps = '0;
    logic [15:0] c1_period = '0;
    logic        c1_step, c1_dir, c1_busy, c1_done, c1_aborted;
    logic [23:0] c1_left;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    bit exp_step [MAXC];
    bit exp_busy [MAXC];
    bit exp_done [MAXC];
    bit exp_ab   [MAXC];
    bit exp_dir  [MAXC];
    int exp_left [MAXC];
    bit m_rdy;
    int pq[$];
    int want[$];

    stepper_step_gen #(.CNT_W(24), .DIV_W(16), .START_PERIOD(16'd8), .RAMP_DEC(16'd2)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .cmd_period(cmd_period), .abort(abort),
        .step_en(step_en), .step_dir(step_dir), .busy(busy), .done(done),
        .aborted(aborted), .steps_left(steps_left)
    );

    stepper_step_gen #(.CNT_W(24), .DIV_W(16), .START_PERIOD(16'd1), .RAMP_DEC(16'd2)) dut1 (
        .clk(clk), .rst(rst), .cmd_valid(c1_valid), .cmd_ready(c1_ready),
        .cmd_steps(c1_steps), .cmd_dir(1'b1), .cmd_period(c1_period), .abort(1'b0),
        .step_en(c1_step), .step_dir(c1_dir), .busy(c1_busy), .done(c1_done),
        .aborted(c1_aborted), .steps_left(c1_left)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
        end
    endtask

    // From cycle 'from' on: no motion, outputs hold the given count and direction.
    task automatic fill_idle(input int from, input int left, input bit d);
        for (int c = from; c < MAXC; c++) begin
            exp_step[c] = 1'b0;
            exp_busy[c] = 1'b0;
            exp_done[c] = 1'b0;
            exp_ab[c]   = 1'b0;
            exp_dir[c]  = d;
            exp_left[c] = left;
        end
    endtask

    // Expected pulse train of a move accepted in cycle k, from the ramp rules.
    task automatic model_cmd(input int k, input int n, input int p, input bit d);
        int t, cur, ramp, at, mode;  // mode: 0 accel, 1 ramped cruise, 2 plain cruise, 3 decel
        t    = (p < 1) ? 1 : p;
        cur  = START;
        ramp = 0;
        mode = (t < START) ? 0 : 2;
        at   = k;
        fill_idle(k + 1, n, d);
        for (int i = 1; i <= n; i++) begin
            at += cur;
            if (at >= MAXC - 1) break;
            exp_step[at] = 1'b1;
            for (int c = at + 1; c < MAXC; c++) exp_left[c] = n - i;
            if (n - i == 0) break;
            if (mode != 2 && (n - i) <= ramp) begin
                mode = 3;
                cur  = (cur + DEC > START) ? START : cur + DEC;
                ramp = (ramp > 0) ? ramp - 1 : 0;
            end else if (mode == 0) begin
                cur = (cur - DEC < t) ? t : cur - DEC;
                ramp++;
                if (cur == t) mode = 1;
            end
        end
        for (int c = k + 1; c <= at && c < MAXC; c++) exp_busy[c] = 1'b1;
        if (at + 1 < MAXC) exp_done[at + 1] = 1'b1;
    endtask

    task automatic model_abort(input int a);
        int left;
        left = exp_left[a] - (exp_step[a] ? 1 : 0);
        fill_idle(a + 1, left, exp_dir[a]);
        exp_done[a + 1] = 1'b1;
        exp_ab[a + 1]   = 1'b1;
    endtask

    // Per-cycle comparison against the model, then advance the model with this cycle's inputs.
    always @(negedge clk) begin
        if (cyc >= 1 && cyc < MAXC - 2) begin
            m_rdy = !exp_busy[cyc] && !rst;
            chk("step_en",    int'(step_en),    int'(exp_step[cyc]));
            chk("busy",       int'(busy),       int'(exp_busy[cyc]));
            chk("done",       int'(done),       int'(exp_done[cyc]));
            chk("aborted",    int'(aborted),    int'(exp_ab[cyc]));
            chk("step_dir",   int'(step_dir),   int'(exp_dir[cyc]));
            chk("steps_left", int'(steps_left), exp_left[cyc]);
            chk("cmd_ready",  int'(cmd_ready),  int'(m_rdy));
            if (step_en) pq.push_back(cyc);
            if (rst) fill_idle(cyc + 1, 0, 1'b0);
            else if (cmd_valid && m_rdy) model_cmd(cyc, int'(cmd_steps), int'(cmd_period), cmd_dir);
            else if (abort && exp_busy[cyc]) model_abort(cyc);
        end
    end

    task automatic issue(input int n, input int p, input bit d, output int k);
        @(posedge clk); #1;
        cmd_steps  = 24'(n);
        cmd_period = 16'(p);
        cmd_dir    = d;
        cmd_valid  = 1'b1;
        k = cyc;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm, output int dc);
        dc = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) begin
                dc = cyc;
                break;
            end
        end
        if (dc < 0) chk({nm, "_timeout"}, 0, 1);
    endtask

    // Run a move and compare pulse offsets (from handshake cycle) against 'want'.
    task automatic run_move(input string nm, input int n, input int p, input bit d, input int done_off);
        int k, dc;
        pq.delete();
        issue(n, p, d, k);
        wait_done(nm, dc);
        chk({nm, "_npulse"}, pq.size(), want.size());
        for (int i = 0; i < want.size() && i < pq.size(); i++)
            chk({nm, "_pulse_at"}, pq[i] - k, want[i]);
        chk({nm, "_done_at"}, dc - k, done_off);
        chk({nm, "_aborted"}, int'(aborted), 0);
        chk({nm, "_left_end"}, int'(steps_left), 0);
    endtask

    initial begin
        int k, dc, np, s3, ndone;
        fill_idle(0, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_step_en", int'(step_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_left", int'(steps_left), 0);
        chk("rst_ready", int'(cmd_ready), 1);

        want = '{8, 16, 24};
        run_move("cruise", 3, 10, 1'b1, 25);

        want = '{8, 14, 18, 22, 28, 36};
        run_move("trap", 6, 4, 1'b0, 37);

        want = '{8, 14, 22};
        run_move("tri", 3, 2, 1'b1, 23);

        want.delete();
        run_move("zero", 0, 5, 1'b0, 1);

        // Abort two cycles after the third step while a second command is held.
        pq.delete();
        issue(10, 4, 1'b1, k);
        cmd_valid = 1'b1; cmd_steps = 24'd5; cmd_period = 16'd3; cmd_dir = 1'b0;
        np = 0; s3 = -1;
        for (int i = 0; i < 100 && np < 3; i++) begin
            @(negedge clk);
            if (step_en) begin
                np++;
                s3 = cyc;
            end
        end
        chk("abort_ready_held", int'(cmd_ready), 0);
        chk("abort_third_at", s3 - k, 18);
        @(posedge clk); #1;
        @(posedge clk); #1;
        abort = 1'b1; cmd_valid = 1'b0;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_done", int'(done), 1);
        chk("abort_flag", int'(aborted), 1);
        chk("abort_left", int'(steps_left), 7);
        chk("abort_dir", int'(step_dir), 1);
        repeat (30) @(negedge clk);
        chk("abort_npulse", pq.size(), 3);

        // Reset in the middle of a plain cruise.
        pq.delete();
        issue(5, 10, 1'b1, k);
        repeat (11) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_step_en", int'(step_en), 0);
        chk("mrst_dir", int'(step_dir), 0);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_done", int'(done), 0);
        chk("mrst_left", int'(steps_left), 0);
        chk("mrst_ready", int'(cmd_ready), 1);
        ndone = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("mrst_no_done", ndone, 0);
        chk("mrst_npulse", pq.size(), 1);
        want = '{8, 16};
        run_move("after_rst", 2, 10, 1'b0, 17);

        // Period 0 with unit start period: a pulse every cycle.
        @(posedge clk); #1;
        c1_steps = 24'd4; c1_period = 16'd0; c1_valid = 1'b1;
        @(posedge clk); #1;
        c1_valid = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            chk("clamp_step", int'(c1_step), (i <= 4) ? 1 : 0);
            chk("clamp_done", int'(c1_done), (i == 5) ? 1 : 0);
            if (i <= 4) chk("clamp_left", int'(c1_left), 5 - i);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog");
    end

endmodule
